reval_stream_host: RTL

Stream-side host for the cell-board evaluator. It accepts a board as a stream of 8-bit words, assembles the NUM_CELLS-bit vector, and drives the evaluator's start/done handshake. It then captures the evaluated board and streams it back out as words. It sits between the system's byte-stream fabric and the evaluator's parallel data_in/data_out/start/done port.

---
 rtl/reval_stream_host_pkg.sv | 19 +
 rtl/reval_stream_host_cell_word_mux.sv | 27 ++
 rtl/reval_stream_host.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/reval_stream_host_pkg.sv
// Shared types and constants for the stream-side evaluator host.
// State encoding, stream word width and the word-count helper.
package reval_stream_host_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_UNLOAD
  } state_t;

  function automatic int num_words(input int cells, input int w);
    return (cells + w - 1) / w;
  endfunction

endpackage

// File: rtl/reval_stream_host_cell_word_mux.sv
// Selects word sel of a cell vector; cells beyond NUM_CELLS read as 0.
// Purely combinational, no backpressure.
module reval_stream_host_cell_word_mux #(
  parameter int NUM_CELLS = 25,
  parameter int WORD_W    = 8,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CELLS-1:0] cells,
  input  logic [IDX_W-1:0]     sel,
  output logic [WORD_W-1:0]    word
);

  localparam int NUM_WORDS = reval_stream_host_pkg::num_words(NUM_CELLS, WORD_W);
  localparam int PAD_W     = NUM_WORDS * WORD_W;

  logic [PAD_W-1:0] padded;

  assign padded = PAD_W'(cells);

  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (sel == IDX_W'(k)) word = padded[k*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/reval_stream_host.sv
// Stream host for the cell-board evaluator: words in -> board -> start/done -> words out.
// Latency: last input word t -> eval_start t+1; eval_done d -> first output word d+1.
// Backpressure: in_ready only in IDLE/LOAD; out_data held while out_ready low.
// Optional REVAL_ITERATE_EN: gen_count port, runs several generations per frame.
module reval_stream_host
  import reval_stream_host_pkg::*;
#(
  parameter int NUM_CELLS = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic                 eval_start,
  input  logic                 eval_done,
  output logic [NUM_CELLS-1:0] eval_data_in,
  input  logic [NUM_CELLS-1:0] eval_data_out,
`ifdef REVAL_ITERATE_EN
  input  logic [7:0]           gen_count,
`endif
  output logic                 busy
);

  localparam int NUM_WORDS = num_words(NUM_CELLS, WORD_W);
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int PAD_W     = NUM_WORDS * WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t               state;
  logic [NUM_CELLS-1:0] board;
  logic [IDX_W-1:0]     in_cnt;
  logic [IDX_W-1:0]     out_cnt;
  logic [WORD_W-1:0]    lane_mask;
  logic [WORD_W-1:0]    out_word;
  logic [PAD_W-1:0]     wr_vec;
  logic [NUM_CELLS-1:0] board_wr;
`ifdef REVAL_ITERATE_EN
  logic [7:0]           remaining;
`endif

  // Lane mask marks which bits of the current input word map onto real cells.
  reval_stream_host_cell_word_mux #(
    .NUM_CELLS(NUM_CELLS),
    .WORD_W   (WORD_W),
    .IDX_W    (IDX_W)
  ) u_lane_mask (
    .cells({NUM_CELLS{1'b1}}),
    .sel  (in_cnt),
    .word (lane_mask)
  );

  reval_stream_host_cell_word_mux #(
    .NUM_CELLS(NUM_CELLS),
    .WORD_W   (WORD_W),
    .IDX_W    (IDX_W)
  ) u_out_mux (
    .cells(board),
    .sel  (out_cnt),
    .word (out_word)
  );

  always_comb begin
    wr_vec = PAD_W'(board);
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (in_cnt == IDX_W'(k)) wr_vec[k*WORD_W +: WORD_W] = in_data & lane_mask;
    end
  end

  assign board_wr = wr_vec[NUM_CELLS-1:0];

  generate
    if (PAD_W > NUM_CELLS) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^wr_vec[PAD_W-1:NUM_CELLS];
    end
  endgenerate

  assign eval_data_in = board;
  assign out_data     = out_valid ? out_word : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      board      <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      eval_start <= 1'b0;
      busy       <= 1'b0;
`ifdef REVAL_ITERATE_EN
      remaining  <= '0;
`endif
    end else begin
      eval_start <= 1'b0;
      case (state)
        ST_IDLE, ST_LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            board <= board_wr;
            busy  <= 1'b1;
`ifdef REVAL_ITERATE_EN
            if (state == ST_IDLE) remaining <= (gen_count == 8'd0) ? 8'd1 : gen_count;
`endif
            if (in_cnt == LAST_IDX) begin
              in_cnt     <= '0;
              in_ready   <= 1'b0;
              eval_start <= 1'b1;
              state      <= ST_START;
            end else begin
              in_cnt <= in_cnt + 1'b1;
              state  <= ST_LOAD;
            end
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (eval_done) begin
            board   <= eval_data_out;
            out_cnt <= '0;
`ifdef REVAL_ITERATE_EN
            // Feed the result straight back for the next generation.
            if (remaining > 8'd1) begin
              remaining  <= remaining - 8'd1;
              eval_start <= 1'b1;
              state      <= ST_START;
            end else begin
              out_valid <= 1'b1;
              state     <= ST_UNLOAD;
            end
`else
            out_valid <= 1'b1;
            state     <= ST_UNLOAD;
`endif
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (out_cnt == LAST_IDX) begin
              out_cnt   <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
